// File: rtl/probit_period_ctrl.sv
// Period sequencer and result holder for the probit GT/LT accumulator.
// Define PROBIT_CONTINUOUS_EN for back-to-back periods after one start.
module probit_period_ctrl #(
   parameter int NBITS     = 21,
   parameter int NCLK_BITS = 18
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [NCLK_BITS-1:0] nclocks_i,
   output logic                 busy_o,
   output logic                 acc_rst_o,
   output logic                 acc_ce_o,
   input  logic [NBITS-1:0]     gt_sum_i,
   input  logic [NBITS-1:0]     lt_sum_i,
   output logic [NBITS-1:0]     gt_o,
   output logic [NBITS-1:0]     lt_o,
   output logic                 valid_o,
   input  logic                 ack_i,
   output logic                 overrun_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_CAPTURE
   } state_t;

   localparam logic [NCLK_BITS-1:0] CNT_ONE = NCLK_BITS'(1);

   state_t               state;
   logic [NCLK_BITS-1:0] len;
   logic [NCLK_BITS-1:0] cnt;
   logic                 clr_q;

   assign acc_rst_o = clr_q | rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         len       <= '0;
         cnt       <= '0;
         clr_q     <= 1'b0;
         busy_o    <= 1'b0;
         acc_ce_o  <= 1'b0;
         gt_o      <= '0;
         lt_o      <= '0;
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         if (ack_i) begin
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
         end
         unique case (state)
            S_IDLE: begin
               if (start_i) begin
                  len    <= nclocks_i;
                  state  <= S_CLEAR;
                  busy_o <= 1'b1;
                  clr_q  <= 1'b1;
               end
            end
            S_CLEAR: begin
               cnt   <= len;
               clr_q <= 1'b0;
               if (len == '0) begin
                  state <= S_CAPTURE;
               end else begin
                  state    <= S_RUN;
                  acc_ce_o <= 1'b1;
               end
            end
            S_RUN: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state    <= S_CAPTURE;
                  acc_ce_o <= 1'b0;
               end
            end
            S_CAPTURE: begin
               gt_o    <= gt_sum_i;
               lt_o    <= lt_sum_i;
               // a coincident ack consumes the old result, not the new one
               valid_o <= 1'b1;
               if (valid_o && !ack_i) overrun_o <= 1'b1;
`ifdef PROBIT_CONTINUOUS_EN
               state <= S_CLEAR;
               clr_q <= 1'b1;
`else
               state  <= S_IDLE;
               busy_o <= 1'b0;
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_probit_period_ctrl.sv
// Bench for probit_period_ctrl with a behavioural accumulator and
// window-sum reference built from per-cycle input history.
module tb_probit_period_ctrl;

   localparam int NB = 21;
   localparam int NC = 18;
   localparam int HL = 16384;

   logic          clk;
   logic          rst;
   logic          start;
   logic [NC-1:0] nclk;
   logic          busy;
   logic          acc_rst;
   logic          acc_ce;
   logic [NB-1:0] gs;
   logic [NB-1:0] ls;
   logic [NB-1:0] gt;
   logic [NB-1:0] lt;
   logic          valid;
   logic          ack;
   logic          ovr;

   logic [7:0] gr;
   logic [7:0] lr;
   logic [3:0] gpc;
   logic [3:0] lpc;
   int         cyc;
   int         mode;
   int         hg[0:HL-1];
   int         hl[0:HL-1];
   int         total;
   int         bad;
   bit         m_valid;
   bit         m_ovr;

   probit_period_ctrl #(.NBITS(NB), .NCLK_BITS(NC)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .nclocks_i (nclk),
      .busy_o    (busy),
      .acc_rst_o (acc_rst),
      .acc_ce_o  (acc_ce),
      .gt_sum_i  (gs),
      .lt_sum_i  (ls),
      .gt_o      (gt),
      .lt_o      (lt),
      .valid_o   (valid),
      .ack_i     (ack),
      .overrun_o (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // raw comparator inputs, one new value per cycle, logged by cycle
   always @(posedge clk) begin
      #1;
      case (mode)
         1: begin gr = 8'hFF; lr = 8'h00; end
         2: begin gr = cyc[0] ? 8'h00 : 8'h0F; lr = 8'h01; end
         3: begin gr = 8'hFF; lr = 8'($urandom); end
         default: begin gr = 8'($urandom); lr = 8'($urandom); end
      endcase
      if (cyc < HL) begin
         hg[cyc] = $countones(gr);
         hl[cyc] = $countones(lr);
      end
   end

   // accumulator: registered popcount, then gated running sum
   always @(posedge clk) begin
      gpc <= 4'($countones(gr));
      lpc <= 4'($countones(lr));
      if (acc_rst) begin
         gs <= '0;
         ls <= '0;
      end else if (acc_ce) begin
         gs <= gs + NB'(gpc);
         ls <= ls + NB'(lpc);
      end
   end

   function automatic int win_sum(input int t, input int n, input bit use_lt);
      int s;
      s = 0;
      for (int c = t + 1; c <= t + n; c++)
         s += use_lt ? hl[c] : hg[c];
      return s;
   endfunction

   task automatic do_start(input int n, output int t);
      @(posedge clk); #1;
      start = 1'b1;
      nclk  = NC'(n);
      t     = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      nclk  = NC'($urandom);
   endtask

   task automatic pulse_ack;
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic run_one(input int n, input bit ack_cap, input bit poke);
      int t;
      int ce_n;
      int rdy;
      int c;
      bit win_ok;
      logic [NB-1:0] eg;
      logic [NB-1:0] el;
      do_start(n, t);
      ce_n   = 0;
      rdy    = -1;
      win_ok = 1'b1;
      for (int k = 0; k < n + 40 && rdy < 0; k++) begin
         @(negedge clk);
         c = cyc;
         if (c == t + 3 + n) ack = 1'b0;
         if (ack_cap && c == t + 2 + n) ack = 1'b1;
         if (poke && c == t + 2) begin
            start = 1'b1;
            nclk  = NC'($urandom_range(1, 500));
         end
         if (poke && c == t + 3) start = 1'b0;
         if (acc_ce) ce_n++;
         if (acc_ce !== (c >= t + 2 && c <= t + 1 + n)) win_ok = 1'b0;
         if (acc_rst !== (c == t + 1)) win_ok = 1'b0;
         if (busy === 1'b0) rdy = c;
      end
      start = 1'b0;
      ack   = 1'b0;
      eg = NB'(win_sum(t, n, 1'b0));
      el = NB'(win_sum(t, n, 1'b1));
      if (ack_cap) m_ovr = 1'b0;
      else m_ovr = m_ovr | m_valid;
      m_valid = 1'b1;
      total++;
      if (rdy != t + 3 + n) begin
         bad++;
         $display("FAIL ready_cycle n=%0d: got %0d want %0d", n, rdy, t + 3 + n);
      end
      total++;
      if (ce_n != n) begin
         bad++;
         $display("FAIL ce_count n=%0d: got %0d want %0d", n, ce_n, n);
      end
      total++;
      if (!win_ok) begin
         bad++;
         $display("FAIL ce_rst_window n=%0d: got off-window pulse want exact", n);
      end
      total++;
      if (gt !== eg) begin
         bad++;
         $display("FAIL gt_sum n=%0d: got %0d want %0d", n, gt, eg);
      end
      total++;
      if (lt !== el) begin
         bad++;
         $display("FAIL lt_sum n=%0d: got %0d want %0d", n, lt, el);
      end
      total++;
      if (valid !== m_valid) begin
         bad++;
         $display("FAIL valid n=%0d: got %b want %b", n, valid, m_valid);
      end
      total++;
      if (ovr !== m_ovr) begin
         bad++;
         $display("FAIL overrun n=%0d: got %b want %b", n, ovr, m_ovr);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, acc_ce, valid, ovr} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags: got %b want 0000", {busy, acc_ce, valid, ovr});
      end
      total++;
      if (gt !== '0 || lt !== '0) begin
         bad++;
         $display("FAIL reset_sums: got %0d/%0d want 0/0", gt, lt);
      end
      total++;
      if (acc_rst !== 1'b1) begin
         bad++;
         $display("FAIL reset_acc_rst: got %b want 1", acc_rst);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (acc_rst !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: got rst=%b busy=%b want 0 0", acc_rst, busy);
      end
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

`ifndef PROBIT_CONTINUOUS_EN
   task automatic test_constant;
      mode = 1;
      run_one(100, 1'b0, 1'b0);
      total++;
      if (gt !== NB'(800) || lt !== '0) begin
         bad++;
         $display("FAIL constant: got %0d/%0d want 800/0", gt, lt);
      end
      pulse_ack();
   endtask

   task automatic test_alternating;
      mode = 2;
      run_one(1000, 1'b0, 1'b0);
      total++;
      if (gt !== NB'(2000) || lt !== NB'(1000)) begin
         bad++;
         $display("FAIL alternating: got %0d/%0d want 2000/1000", gt, lt);
      end
      pulse_ack();
   endtask

   task automatic test_zero_len;
      mode = 1;
      run_one(0, 1'b0, 1'b0);
      total++;
      if (gt !== '0 || lt !== '0) begin
         bad++;
         $display("FAIL zero_len: got %0d/%0d want 0/0", gt, lt);
      end
      pulse_ack();
   endtask

   task automatic test_overrun;
      mode = 0;
      run_one(5, 1'b0, 1'b0);
      run_one(7, 1'b0, 1'b0);
      total++;
      if (ovr !== 1'b1 || valid !== 1'b1) begin
         bad++;
         $display("FAIL overrun_set: got ovr=%b valid=%b want 1 1", ovr, valid);
      end
      pulse_ack();
      total++;
      if (ovr !== 1'b0 || valid !== 1'b0) begin
         bad++;
         $display("FAIL overrun_ack: got ovr=%b valid=%b want 0 0", ovr, valid);
      end
      run_one(4, 1'b0, 1'b0);
      run_one(6, 1'b1, 1'b0);
      total++;
      if (ovr !== 1'b0 || valid !== 1'b1) begin
         bad++;
         $display("FAIL coincident_ack: got ovr=%b valid=%b want 0 1", ovr, valid);
      end
      pulse_ack();
   endtask

   task automatic test_reset_midrun;
      int t;
      mode = 3;
      run_one(3, 1'b0, 1'b0);
      do_start(30, t);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (acc_rst !== 1'b1) begin
         bad++;
         $display("FAIL midrun_acc_rst: got %b want 1", acc_rst);
      end
      @(negedge clk);
      rst = 1'b0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      total++;
      if ({busy, acc_ce, valid, ovr} !== 4'b0000 || gt !== '0) begin
         bad++;
         $display("FAIL midrun_abort: got %b gt=%0d want 0000 gt=0",
                  {busy, acc_ce, valid, ovr}, gt);
      end
      repeat (40) @(negedge clk);
      total++;
      if (valid !== 1'b0 || gt !== '0) begin
         bad++;
         $display("FAIL midrun_no_capture: got valid=%b gt=%0d want 0 0", valid, gt);
      end
      run_one(10, 1'b0, 1'b0);
      total++;
      if (gt !== NB'(80)) begin
         bad++;
         $display("FAIL after_reset_run: got %0d want 80", gt);
      end
      pulse_ack();
   endtask

   task automatic test_random;
      mode = 0;
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 1) == 1) pulse_ack();
         run_one($urandom_range(0, 40), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      end
   endtask
`else
   task automatic test_continuous;
      int t;
      int prev;
      int seen;
      mode = 1;
      prev = -1;
      do_start(50, t);
      for (int p = 0; p < 3; p++) begin
         seen = -1;
         for (int k = 0; k < 100 && seen < 0; k++) begin
            @(negedge clk);
            if (valid === 1'b1) seen = cyc;
         end
         total++;
         if (seen < 0 || gt !== NB'(400) || lt !== '0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL cont_period %0d: got gt=%0d busy=%b want 400 1", p, gt, busy);
         end
         total++;
         if (seen != (p == 0 ? t + 53 : prev + 52)) begin
            bad++;
            $display("FAIL cont_spacing %0d: got %0d want %0d",
                     p, seen, p == 0 ? t + 53 : prev + 52);
         end
         prev = seen;
         ack = 1'b1;
         @(negedge clk);
         ack = 1'b0;
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      mode  = 0;
      rst   = 1'b1;
      start = 1'b0;
      ack   = 1'b0;
      nclk  = '0;
      test_reset();
`ifdef PROBIT_CONTINUOUS_EN
      test_continuous();
`else
      test_constant();
      test_alternating();
      test_zero_len();
      test_overrun();
      test_reset_midrun();
      test_random();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
